key_command_decoder: RTL and testbench

Parametrised keyboard command front-end between the PS/2 `keyboard` receiver and the game control FSM. It replaces the per-key one-off handlers with NUM_KEYS identical channels. Each channel matches one scan code on the held-code bus and produces state-qualified press, release, hold and auto-repeat events. A lockout rule guarantees that a key already down when its channel becomes enabled never registers.

---
 rtl/key_pkg.sv | 20 ++
 rtl/key_channel.sv | 112 +++++++++++
 rtl/key_command_decoder.sv | 72 +++++++
 tb/tb_key_command_decoder.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the keyboard command front-end.
//   key_state_t : per-channel FSM state encoding (IDLE, LOCKOUT, DOWN, HELD)
//   SC_*        : PS/2 set-2 scan codes used by the game, SC_NONE = no key held
package key_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOCKOUT = 2'd1,
    DOWN    = 2'd2,
    HELD    = 2'd3
  } key_state_t;

  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ESC    = 8'h76;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_ONE    = 8'h16;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_NONE   = 8'h00;

endpackage

// File: rtl/key_channel.sv
// One key channel: matches CODE on the registered held-code bus and produces
// press / release / hold-repeat events, qualified by enable.
// Ports:
//   Clock, reset   : clock, synchronous active-low reset
//   kbReg          : registered held scan code (8'h00 = no key)
//   enable         : channel qualifier
//   pressPulse     : one-cycle event on key-down while enabled
//   releasePulse   : one-cycle event on key-up from DOWN/HELD
//   repeatPulse    : one-cycle event on hold entry and every REPEAT_CYCLES after
//   state          : current FSM state (debug / held decode)
module key_channel
  import key_pkg::*;
#(
  parameter logic [7:0] CODE          = SC_SPACE,
  parameter int         HOLD_CYCLES   = 12500000,
  parameter int         REPEAT_CYCLES = 2500000
) (
  input  logic       Clock,
  input  logic       reset,
  input  logic [7:0] kbReg,
  input  logic       enable,
  output logic       pressPulse,
  output logic       releasePulse,
  output logic       repeatPulse,
  output logic [1:0] state
);

  localparam int MAX_CYCLES = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] HOLD_LAST   = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REPEAT_LAST = CW'(REPEAT_CYCLES - 1);

  key_state_t    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          press_d, release_d, repeat_d;
  logic          match;

  assign match = (kbReg == CODE) && (kbReg != SC_NONE);
  assign state = state_q;

  // Priority inside DOWN/HELD: key-up beats disable, disable beats counter.
  // A disable while down drops to LOCKOUT so the key cannot re-press until
  // it has been physically released.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    repeat_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (match) begin
          if (enable) begin
            state_d = DOWN;
            press_d = 1'b1;
            count_d = '0;
          end else begin
            state_d = LOCKOUT;
          end
        end
      end
      LOCKOUT: begin
        if (!match) state_d = IDLE;
      end
      DOWN: begin
        if (!match) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (!enable) begin
          state_d = LOCKOUT;
        end else if (count_q == HOLD_LAST) begin
          state_d  = HELD;
          repeat_d = 1'b1;
          count_d  = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      HELD: begin
        if (!match) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else if (!enable) begin
          state_d = LOCKOUT;
        end else if (count_q == REPEAT_LAST) begin
          repeat_d = 1'b1;
          count_d  = '0;
        end else begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (!reset) begin
      state_q      <= IDLE;
      count_q      <= '0;
      pressPulse   <= 1'b0;
      releasePulse <= 1'b0;
      repeatPulse  <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pressPulse   <= press_d;
      releasePulse <= release_d;
      repeatPulse  <= repeat_d;
    end
  end

endmodule

// File: rtl/key_command_decoder.sv
// Keyboard command front-end: registers the held scan code and fans it out
// to NUM_KEYS identical key channels.
// Ports:
//   Clock, reset  : clock, synchronous active-low reset
//   kbData        : held scan code from the PS/2 receiver (8'h00 = no key)
//   enable        : per-channel qualifier
//   pressPulse    : per-channel one-cycle press event
//   releasePulse  : per-channel one-cycle release event
//   repeatPulse   : per-channel hold entry / auto-repeat event
//   held          : per-channel level, channel in DOWN or HELD
//   anyHeld       : OR of held
//   activeKey     : lowest channel index with held set, 0 when none
module key_command_decoder
  import key_pkg::*;
#(
  parameter int                    NUM_KEYS      = 5,
  parameter logic [NUM_KEYS*8-1:0] KEY_CODES     = {8'h59, 8'h16, 8'h5A, 8'h76, 8'h29},
  parameter int                    HOLD_CYCLES   = 12500000,
  parameter int                    REPEAT_CYCLES = 2500000,
  localparam int                   AW            = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
) (
  input  logic                Clock,
  input  logic                reset,
  input  logic [7:0]          kbData,
  input  logic [NUM_KEYS-1:0] enable,
  output logic [NUM_KEYS-1:0] pressPulse,
  output logic [NUM_KEYS-1:0] releasePulse,
  output logic [NUM_KEYS-1:0] repeatPulse,
  output logic [NUM_KEYS-1:0] held,
  output logic                anyHeld,
  output logic [AW-1:0]       activeKey
);

  logic [7:0] kbReg;
  logic [1:0] chan_state [NUM_KEYS];

  always_ff @(posedge Clock) begin
    if (!reset) kbReg <= SC_NONE;
    else        kbReg <= kbData;
  end

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_chan
    key_channel #(
      .CODE          (KEY_CODES[8*g +: 8]),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_channel (
      .Clock        (Clock),
      .reset        (reset),
      .kbReg        (kbReg),
      .enable       (enable[g]),
      .pressPulse   (pressPulse[g]),
      .releasePulse (releasePulse[g]),
      .repeatPulse  (repeatPulse[g]),
      .state        (chan_state[g])
    );
    // held is a decode of the registered state, so it changes on the same
    // edge as the press/release pulses.
    assign held[g] = (chan_state[g] == DOWN) || (chan_state[g] == HELD);
  end

  assign anyHeld = |held;

  // Scan from the top so the lowest held index wins.
  always_comb begin
    activeKey = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (held[i]) activeKey = AW'(i);
    end
  end

endmodule

// File: tb/tb_key_command_decoder.sv
// Directed bench for key_command_decoder with HOLD_CYCLES=8, REPEAT_CYCLES=4
// and the default scan-code table (ch0=29 ch1=76 ch2=5A ch3=16 ch4=59).
// Inputs change and outputs are sampled 1 time unit after each rising edge;
// "n" below counts edges since the stimulus change.
module tb_key_command_decoder;

  logic       Clock;
  logic       reset;
  logic [7:0] kbData;
  logic [4:0] enable;
  logic [4:0] pressPulse;
  logic [4:0] releasePulse;
  logic [4:0] repeatPulse;
  logic [4:0] held;
  logic       anyHeld;
  logic [2:0] activeKey;

  int checks = 0;
  int errors = 0;

  key_command_decoder #(
    .HOLD_CYCLES   (8),
    .REPEAT_CYCLES (4)
  ) dut (
    .Clock        (Clock),
    .reset        (reset),
    .kbData       (kbData),
    .enable       (enable),
    .pressPulse   (pressPulse),
    .releasePulse (releasePulse),
    .repeatPulse  (repeatPulse),
    .held         (held),
    .anyHeld      (anyHeld),
    .activeKey    (activeKey)
  );

  // clock / reset
  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_press"}, 32'(pressPulse), 32'h0);
    check({tag, "_release"}, 32'(releasePulse), 32'h0);
    check({tag, "_repeat"}, 32'(repeatPulse), 32'h0);
    check({tag, "_held"}, 32'(held), 32'h0);
    check({tag, "_any"}, 32'(anyHeld), 32'h0);
    check({tag, "_active"}, 32'(activeKey), 32'h0);
  endtask

  initial begin
    reset  = 1'b0;
    kbData = 8'h00;
    enable = 5'b11111;
    ticks(2);
    check_all_zero("reset");
    reset = 1'b1;
    ticks(2);
    check_all_zero("idle");

    // Short tap on SPACE: 29 seen at edges 1..3, 00 from edge 4.
    kbData = 8'h29;
    for (int n = 1; n <= 7; n++) begin
      tick();
      check("tap_press", 32'(pressPulse), (n == 2) ? 32'h01 : 32'h0);
      check("tap_release", 32'(releasePulse), (n == 5) ? 32'h01 : 32'h0);
      check("tap_held", 32'(held), (n >= 2 && n <= 4) ? 32'h01 : 32'h0);
      check("tap_repeat", 32'(repeatPulse), 32'h0);
      if (n == 3) kbData = 8'h00;
    end

    // Long hold on SPACE: hold entry at edge 10, repeats at 14 and 18.
    kbData = 8'h29;
    for (int n = 1; n <= 20; n++) begin
      tick();
      check("hold_press", 32'(pressPulse), (n == 2) ? 32'h01 : 32'h0);
      check("hold_repeat", 32'(repeatPulse),
            (n == 10 || n == 14 || n == 18) ? 32'h01 : 32'h0);
      check("hold_any", 32'(anyHeld), (n >= 2) ? 32'h1 : 32'h0);
      check("hold_active", 32'(activeKey), 32'h0);
    end
    kbData = 8'h00;
    tick();
    check("hold_rel_early", 32'(releasePulse), 32'h0);
    tick();
    check("hold_release", 32'(releasePulse), 32'h01);
    check("hold_held_off", 32'(held), 32'h0);
    ticks(2);

    // Lockout: ESC already down when channel 1 becomes enabled.
    enable = 5'b11101;
    kbData = 8'h76;
    ticks(3);
    check("lock_press_dis", 32'(pressPulse), 32'h0);
    enable = 5'b11111;
    for (int n = 1; n <= 4; n++) begin
      tick();
      check("lock_press_en", 32'(pressPulse), 32'h0);
      check("lock_held", 32'(held), 32'h0);
    end
    kbData = 8'h00;
    ticks(2);
    check("lock_no_release", 32'(releasePulse), 32'h0);
    kbData = 8'h76;
    tick();
    check("repress_early", 32'(pressPulse), 32'h0);
    tick();
    check("repress_press", 32'(pressPulse), 32'h02);
    check("repress_active", 32'(activeKey), 32'h1);
    kbData = 8'h00;
    ticks(4);

    // Direct key change ENTER -> ONE.
    kbData = 8'h5A;
    ticks(2);
    check("chg_press_a", 32'(pressPulse), 32'h04);
    tick();
    check("chg_active_a", 32'(activeKey), 32'h2);
    kbData = 8'h16;
    tick();
    check("chg_mid_held", 32'(held), 32'h04);
    tick();
    check("chg_release_a", 32'(releasePulse), 32'h04);
    check("chg_press_b", 32'(pressPulse), 32'h08);
    check("chg_held_b", 32'(held), 32'h08);
    check("chg_active_b", 32'(activeKey), 32'h3);
    kbData = 8'h00;
    ticks(4);

    // Abort from HELD by dropping enable, then reset mid-hold.
    kbData = 8'h29;
    ticks(10);
    check("abort_hold_entry", 32'(repeatPulse), 32'h01);
    check("abort_held_before", 32'(held), 32'h01);
    enable = 5'b11110;
    tick();
    check("abort_held_after", 32'(held), 32'h0);
    check("abort_no_release", 32'(releasePulse), 32'h0);
    check("abort_any", 32'(anyHeld), 32'h0);
    enable = 5'b11111;
    kbData = 8'h5A;
    ticks(10);
    check("rst_pre_held", 32'(held), 32'h04);
    reset = 1'b0;
    tick();
    check_all_zero("rst_mid");
    reset = 1'b1;
    tick();
    check_all_zero("rst_after1");
    tick();
    check("rst_repress", 32'(pressPulse), 32'h04);
    check("rst_repress_held", 32'(held), 32'h04);
    kbData = 8'h00;
    ticks(3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
